// File: rtl/impulse_scheduler_if.sv
// Purpose: groups the scheduler's time, configuration, control and pulse outputs into one bundle.
// Latency: none (wiring only); timing is owned by impulse_scheduler.
// Backpressure: none; cfg_wr and stop are fire-and-forget strobes.
interface impulse_scheduler_if;
    logic [63:0] sys_time;
    logic        cfg_wr;
    logic [63:0] cfg_time_start;
    logic [15:0] cfg_n_impulse;
    logic [7:0]  cfg_type;
    logic [31:0] cfg_ti;
    logic [31:0] cfg_tp;
    logic [31:0] cfg_tblank1;
    logic [31:0] cfg_tblank2;
    logic        stop;
    logic        imp_out;
    logic        imp_strobe;
    logic        blank;
    logic [7:0]  imp_type;
    logic [15:0] imp_cnt;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic        late_err;

    // Controller side: drives time and configuration, observes pulses.
    modport master (
        output sys_time, cfg_wr, cfg_time_start, cfg_n_impulse, cfg_type,
               cfg_ti, cfg_tp, cfg_tblank1, cfg_tblank2, stop,
        input  imp_out, imp_strobe, blank, imp_type, imp_cnt, busy, done,
               cfg_err, late_err
    );

    // Scheduler side.
    modport slave (
        input  sys_time, cfg_wr, cfg_time_start, cfg_n_impulse, cfg_type,
               cfg_ti, cfg_tp, cfg_tblank1, cfg_tblank2, stop,
        output imp_out, imp_strobe, blank, imp_type, imp_cnt, busy, done,
               cfg_err, late_err
    );
endinterface

// File: rtl/impulse_scheduler.sv
// Purpose: time-triggered burst generator with pulse, strobe and receiver-blanking outputs.
// Latency: 1 clk from sampled sys_time == start to first imp_out; all outputs registered.
// Backpressure: none; a valid cfg_wr always re-arms, stop always returns to IDLE.
module impulse_scheduler (
    input  logic               clk,
    input  logic               rst_n,
    impulse_scheduler_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] ph_q, ph_d;
    logic [15:0] cnt_q, cnt_d;

    // Shadow copy of the configuration; the FSM never looks at cfg_* directly.
    logic [63:0] ts_q, ts_d;
    logic [15:0] n_q, n_d;
    logic [7:0]  sh_type_q, sh_type_d;
    logic [31:0] ti_q, ti_d, tp_q, tp_d, tb1_q, tb1_d, tb2_q, tb2_d;

    logic        imp_out_q, imp_out_d, strobe_q, strobe_d, blank_q, blank_d;
    logic        busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic        late_err_q, late_err_d;
    logic [7:0]  type_q, type_d;

    // Phase arithmetic is one bit wider so ti+tblank2 cannot wrap.
    logic [32:0] post_end;    // first phase after the post-pulse blank
    logic [32:0] tail_end;    // last phase of the final pulse's post blank
    logic [31:0] pre_start;   // first phase of the pre-pulse blank, floored at 0
    logic        cfg_ok;

    assign post_end  = {1'b0, ti_q} + {1'b0, tb2_q};
    assign tail_end  = post_end - 33'd1;
    assign pre_start = (tp_q > tb1_q) ? (tp_q - tb1_q) : 32'd0;
    assign cfg_ok    = (bus.cfg_n_impulse != 16'd0) && (bus.cfg_ti != 32'd0) &&
                       (bus.cfg_tp > bus.cfg_ti);

    // Next-state and next-output logic; priority is valid cfg, rejected cfg, stop, then FSM.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        ts_d       = ts_q;
        n_d        = n_q;
        sh_type_d  = sh_type_q;
        ti_d       = ti_q;
        tp_d       = tp_q;
        tb1_d      = tb1_q;
        tb2_d      = tb2_q;
        imp_out_d  = 1'b0;
        strobe_d   = 1'b0;
        blank_d    = 1'b0;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        late_err_d = 1'b0;

        if (bus.cfg_wr && cfg_ok) begin
            ts_d      = bus.cfg_time_start;
            n_d       = bus.cfg_n_impulse;
            sh_type_d = bus.cfg_type;
            ti_d      = bus.cfg_ti;
            tp_d      = bus.cfg_tp;
            tb1_d     = bus.cfg_tblank1;
            tb2_d     = bus.cfg_tblank2;
            ph_d      = 32'd0;
            // The first armed cycle would see sys_time+1, so a start at or
            // before now is already missed; report it without ever going busy.
            if (bus.cfg_time_start <= bus.sys_time) begin
                late_err_d = 1'b1;
                state_d    = ST_IDLE;
            end else begin
                state_d = ST_ARMED;
                cnt_d   = 16'd0;
            end
        end else if (bus.cfg_wr) begin
            cfg_err_d = 1'b1;
            state_d   = ST_IDLE;
            ph_d      = 32'd0;
        end else if (bus.stop) begin
            state_d = ST_IDLE;
            ph_d    = 32'd0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (bus.sys_time > ts_q) begin
                        late_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (bus.sys_time == ts_q) begin
                        state_d = ST_RUN;
                        ph_d    = 32'd0;
                        cnt_d   = 16'd1;
                    end else begin
                        blank_d = (ts_q - bus.sys_time) <= {32'd0, tb1_q};
                    end
                end
                ST_RUN: begin
                    if ((cnt_q == n_q) &&
                        ((ph_q == tp_q - 32'd1) || ({1'b0, ph_q} == tail_end))) begin
                        state_d = ST_IDLE;
                        ph_d    = 32'd0;
                        done_d  = 1'b1;
                    end else if (ph_q == tp_q - 32'd1) begin
                        ph_d  = 32'd0;
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        ph_d = ph_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end

        // RUN outputs follow the phase that will be current next cycle.
        if (state_d == ST_RUN) begin
            imp_out_d = ph_d < ti_q;
            strobe_d  = ph_d == 32'd0;
            blank_d   = ({1'b0, ph_d} < post_end) || ((ph_d >= pre_start) && (cnt_d < n_q));
        end
        busy_d = state_d != ST_IDLE;
        type_d = busy_d ? sh_type_d : 8'd0;
    end

    // State, shadow and output registers; reset clears pulse and blank immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ph_q       <= 32'd0;
            cnt_q      <= 16'd0;
            ts_q       <= 64'd0;
            n_q        <= 16'd0;
            sh_type_q  <= 8'd0;
            ti_q       <= 32'd0;
            tp_q       <= 32'd0;
            tb1_q      <= 32'd0;
            tb2_q      <= 32'd0;
            imp_out_q  <= 1'b0;
            strobe_q   <= 1'b0;
            blank_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            late_err_q <= 1'b0;
            type_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            ts_q       <= ts_d;
            n_q        <= n_d;
            sh_type_q  <= sh_type_d;
            ti_q       <= ti_d;
            tp_q       <= tp_d;
            tb1_q      <= tb1_d;
            tb2_q      <= tb2_d;
            imp_out_q  <= imp_out_d;
            strobe_q   <= strobe_d;
            blank_q    <= blank_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            late_err_q <= late_err_d;
            type_q     <= type_d;
        end
    end

    assign bus.imp_out    = imp_out_q;
    assign bus.imp_strobe = strobe_q;
    assign bus.blank      = blank_q;
    assign bus.imp_type   = type_q;
    assign bus.imp_cnt    = cnt_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.late_err   = late_err_q;
endmodule

// File: tb/tb_impulse_scheduler.sv
// Purpose: self-checking bench for impulse_scheduler (directed, table-driven and random bursts).
// Latency: outputs checked 1 ns after each rising edge, sys_time advanced at the same point.
// Backpressure: not applicable; every wait on the DUT is cycle-bounded.
module tb_impulse_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    impulse_scheduler_if bus();
    impulse_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam int K_OK = 0, K_LATE = 1, K_BAD = 2;

    typedef struct packed {
        logic       imp_out, strobe, blank, busy, done, cfg_err, late_err;
        logic [7:0] typ;
        logic [15:0] cnt;
    } outv_t;

    typedef struct {
        longint c, s, n, ti, tp, tb1, tb2, stop_at, cnt0;
        int     kind;
        logic [7:0] typ;
    } burst_t;

    typedef struct {
        logic [15:0] n;
        logic [31:0] ti, tp;
        logic [7:0]  typ;
        logic        exp_err, exp_busy;
        logic [7:0]  exp_type;
    } cfg_vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.sys_time = bus.sys_time + 64'd1;
    endtask

    function automatic outv_t actual();
        outv_t a;
        a.imp_out  = bus.imp_out;
        a.strobe   = bus.imp_strobe;
        a.blank    = bus.blank;
        a.busy     = bus.busy;
        a.done     = bus.done;
        a.cfg_err  = bus.cfg_err;
        a.late_err = bus.late_err;
        a.typ      = bus.imp_type;
        a.cnt      = bus.imp_cnt;
        return a;
    endfunction

    task automatic drive_cfg(input logic [63:0] s, input logic [15:0] n, input logic [31:0] ti,
                             input logic [31:0] tp, input logic [31:0] tb1, input logic [31:0] tb2,
                             input logic [7:0] typ);
        bus.cfg_time_start = s;
        bus.cfg_n_impulse  = n;
        bus.cfg_ti         = ti;
        bus.cfg_tp         = tp;
        bus.cfg_tblank1    = tb1;
        bus.cfg_tblank2    = tb2;
        bus.cfg_type       = typ;
        bus.cfg_wr         = 1'b1;
    endtask

    // Offset (from the first pulse cycle) of the last busy cycle of a burst.
    function automatic longint last_k(input burst_t b);
        longint e;
        e = (b.ti + b.tb2 - 1 < b.tp - 1) ? b.ti + b.tb2 - 1 : b.tp - 1;
        return (b.n - 1) * b.tp + e;
    endfunction

    // Expected outputs in the cycle showing sys_time == t, for a cfg_wr issued at sys_time b.c.
    function automatic outv_t model_base(input burst_t b, input longint t);
        outv_t  o;
        longint k, p, ph, pre, lk;
        o     = '0;
        o.cnt = 16'(b.cnt0);
        if (b.kind == K_BAD) begin
            o.cfg_err = (t == b.c + 1);
        end else if (b.kind == K_LATE) begin
            o.late_err = (t == b.c + 1);
        end else if (t <= b.s) begin
            o.busy  = 1'b1;
            o.typ   = b.typ;
            o.cnt   = 16'd0;
            o.blank = (t >= b.c + 2) && (b.s - (t - 1) <= b.tb1);
        end else begin
            k  = t - b.s - 1;
            lk = last_k(b);
            if (k <= lk) begin
                p       = k / b.tp;
                ph      = k % b.tp;
                pre     = (b.tp > b.tb1) ? b.tp - b.tb1 : 0;
                o.busy    = 1'b1;
                o.typ     = b.typ;
                o.cnt     = 16'(p + 1);
                o.imp_out = (ph < b.ti);
                o.strobe  = (ph == 0);
                o.blank   = (ph < b.ti + b.tb2) || ((ph >= pre) && (p + 1 < b.n));
            end else begin
                o.cnt  = 16'(b.n);
                o.done = (k == lk + 1);
            end
        end
        return o;
    endfunction

    // A stop freezes the count at its value in the stop cycle and leaves everything else quiet.
    function automatic outv_t model_at(input burst_t b, input longint t);
        outv_t o, r;
        if (b.stop_at >= 0 && t > b.stop_at) begin
            o     = model_base(b, b.stop_at);
            r     = '0;
            r.cnt = o.cnt;
            return r;
        end
        return model_base(b, t);
    endfunction

    function automatic longint end_time(input burst_t b);
        if (b.kind == K_OK) return b.s + 1 + last_k(b) + 2;
        return b.c + 3;
    endfunction

    // Issue the configuration in the current cycle (sys_time == b.c) and check every following cycle.
    task automatic run_burst(input burst_t b, input string tag);
        drive_cfg(64'(b.s), 16'(b.n), 32'(b.ti), 32'(b.tp), 32'(b.tb1), 32'(b.tb2), b.typ);
        for (longint t = b.c + 1; t <= end_time(b); t++) begin
            tick();
            bus.cfg_wr = 1'b0;
            bus.stop   = (t == b.stop_at);
            check($sformatf("%s t=%0d", tag, t), 64'(actual()), 64'(model_at(b, t)));
        end
        bus.stop = 1'b0;
    endtask

    function automatic logic in_any(input longint t, input longint a0, input longint a1,
                                    input longint b0, input longint b1,
                                    input longint c0, input longint c1);
        return (t >= a0 && t <= a1) || (t >= b0 && t <= b1) || (t >= c0 && t <= c1);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_vec_t tbl[8];
        burst_t   b;
        longint   t, last_cnt;
        int       guard;
        logic     found, saw_done;

        tbl[0] = '{16'd0,     32'd4,          32'd10,         8'h01, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{16'd3,     32'd0,          32'd10,         8'h02, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{16'd3,     32'd10,         32'd10,         8'h03, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{16'd3,     32'd11,         32'd10,         8'h04, 1'b1, 1'b0, 8'h00};
        tbl[4] = '{16'd1,     32'd1,          32'd1,          8'h05, 1'b1, 1'b0, 8'h00};
        tbl[5] = '{16'd3,     32'd4,          32'd10,         8'h96, 1'b0, 1'b1, 8'h96};
        tbl[6] = '{16'd1,     32'd1,          32'd2,          8'h6B, 1'b0, 1'b1, 8'h6B};
        tbl[7] = '{16'hFFFF,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  8'hE1, 1'b0, 1'b1, 8'hE1};

        rst_n = 1'b0;
        bus.sys_time = 64'd0;
        bus.cfg_wr = 1'b0;
        bus.cfg_time_start = 64'd0;
        bus.cfg_n_impulse = 16'd0;
        bus.cfg_type = 8'd0;
        bus.cfg_ti = 32'd0;
        bus.cfg_tp = 32'd0;
        bus.cfg_tblank1 = 32'd0;
        bus.cfg_tblank2 = 32'd0;
        bus.stop = 1'b0;

        // Reset state.
        tick(); tick(); tick();
        check("reset_outputs", 64'(actual()), 64'd0);
        rst_n = 1'b1;

        // Late start: start=50 written at sys_time=60.
        while (bus.sys_time < 64'd60) tick();
        drive_cfg(64'd50, 16'd3, 32'd4, 32'd10, 32'd2, 32'd3, 8'h11);
        tick();
        bus.cfg_wr = 1'b0;
        check("late_err_pulse", 64'(bus.late_err), 64'd1);
        check("late_busy", 64'(bus.busy), 64'd0);
        check("late_imp_out", 64'(bus.imp_out), 64'd0);
        tick();
        check("late_err_one_cycle", 64'(bus.late_err), 64'd0);
        check("late_busy_after", 64'(bus.busy), 64'd0);

        // Nominal burst: start=120, n=3, ti=4, tp=10, tb1=2, tb2=3, written at sys_time=100.
        while (bus.sys_time < 64'd100) tick();
        drive_cfg(64'd120, 16'd3, 32'd4, 32'd10, 32'd2, 32'd3, 8'hA5);
        for (int i = 0; i < 50; i++) begin
            tick();
            bus.cfg_wr = 1'b0;
            t = longint'(bus.sys_time);
            check($sformatf("nom imp_out t=%0d", t), 64'(bus.imp_out),
                  64'(in_any(t, 121, 124, 131, 134, 141, 144)));
            check($sformatf("nom blank t=%0d", t), 64'(bus.blank),
                  64'(in_any(t, 119, 127, 129, 137, 139, 147)));
            check($sformatf("nom done t=%0d", t), 64'(bus.done), 64'(t == 148));
            if (t == 101) check("nom busy_armed", 64'({bus.busy, bus.imp_type}), 64'h1A5);
            if (t == 121) check("nom first_pulse", 64'({bus.imp_strobe, bus.imp_cnt}), 64'h1_0001);
            if (t == 131) check("nom second_strobe", 64'({bus.imp_strobe, bus.imp_cnt}), 64'h1_0002);
        end
        check("nom final_cnt", 64'(bus.imp_cnt), 64'd3);
        check("nom final_busy_type", 64'({bus.busy, bus.imp_type}), 64'd0);

        // Configuration acceptance table, each applied from IDLE.
        for (int i = 0; i < 8; i++) begin
            drive_cfg(bus.sys_time + 64'd50, tbl[i].n, tbl[i].ti, tbl[i].tp, 32'd2, 32'd3, tbl[i].typ);
            tick();
            bus.cfg_wr = 1'b0;
            check($sformatf("tbl[%0d] cfg_err", i), 64'(bus.cfg_err), 64'(tbl[i].exp_err));
            check($sformatf("tbl[%0d] busy", i), 64'(bus.busy), 64'(tbl[i].exp_busy));
            check($sformatf("tbl[%0d] imp_type", i), 64'(bus.imp_type), 64'(tbl[i].exp_type));
            bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
            check($sformatf("tbl[%0d] err_cleared", i), 64'({bus.cfg_err, bus.busy}), 64'd0);
        end

        // Valid cfg_wr together with stop: the configuration wins.
        drive_cfg(bus.sys_time + 64'd40, 16'd2, 32'd2, 32'd5, 32'd1, 32'd1, 8'h42);
        bus.stop = 1'b1;
        tick();
        bus.cfg_wr = 1'b0;
        bus.stop = 1'b0;
        check("cfg_beats_stop", 64'({bus.busy, bus.imp_type}), 64'h142);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stop_to_idle", 64'(bus.busy), 64'd0);

        // Re-arm during pulse 2 of a 5-pulse burst.
        drive_cfg(bus.sys_time + 64'd5, 16'd5, 32'd3, 32'd8, 32'd1, 32'd2, 8'h5A);
        found = 1'b0;
        saw_done = 1'b0;
        guard = 0;
        while (!found && guard < 200) begin
            tick();
            bus.cfg_wr = 1'b0;
            guard++;
            saw_done = saw_done | bus.done;
            if (bus.imp_cnt == 16'd2 && bus.imp_out) found = 1'b1;
        end
        check("rearm reach_pulse2", 64'(found), 64'd1);
        check("rearm no_early_done", 64'(saw_done), 64'd0);
        b = '{c: longint'(bus.sys_time), s: longint'(bus.sys_time) + 12, n: 2, ti: 2, tp: 6,
              tb1: 3, tb2: 1, stop_at: -1, cnt0: 0, kind: K_OK, typ: 8'hC3};
        run_burst(b, "rearm");

        // Stop in the post-pulse blank of the final pulse.
        drive_cfg(bus.sys_time + 64'd3, 16'd2, 32'd3, 32'd10, 32'd0, 32'd4, 8'h3C);
        found = 1'b0;
        guard = 0;
        while (!found && guard < 100) begin
            tick();
            bus.cfg_wr = 1'b0;
            guard++;
            if (bus.imp_cnt == 16'd2 && !bus.imp_out && bus.blank) found = 1'b1;
        end
        check("stop reach_post_blank", 64'(found), 64'd1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stop outputs_low", 64'({bus.blank, bus.busy, bus.imp_out}), 64'd0);
        check("stop cnt_held", 64'(bus.imp_cnt), 64'd2);
        saw_done = bus.done;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw_done = saw_done | bus.done;
        end
        check("stop no_done", 64'(saw_done), 64'd0);

        // Reset mid-pulse drops outputs without a clock edge.
        drive_cfg(bus.sys_time + 64'd3, 16'd4, 32'd5, 32'd10, 32'd1, 32'd1, 8'h77);
        found = 1'b0;
        guard = 0;
        while (!found && guard < 100) begin
            tick();
            bus.cfg_wr = 1'b0;
            guard++;
            if (bus.imp_out) found = 1'b1;
        end
        check("rst reach_pulse", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst async imp_out", 64'(bus.imp_out), 64'd0);
        check("rst async blank", 64'(bus.blank), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("post_reset idle %0d", i), 64'(actual()), 64'd0);
        end

        // Random bursts against the reference model.
        last_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            b.c    = longint'(bus.sys_time);
            b.kind = ($urandom_range(0, 9) == 0) ? K_BAD :
                     ($urandom_range(0, 8) == 0) ? K_LATE : K_OK;
            b.n    = longint'($urandom_range(1, 4));
            b.ti   = longint'($urandom_range(1, 5));
            b.tp   = b.ti + longint'($urandom_range(1, 6));
            b.tb1  = longint'($urandom_range(0, 12));
            b.tb2  = longint'($urandom_range(0, 12));
            b.typ  = 8'($urandom_range(1, 255));
            b.cnt0 = last_cnt;
            b.stop_at = -1;
            if (b.kind == K_BAD) begin
                case ($urandom_range(0, 2))
                    0: b.n = 0;
                    1: b.ti = 0;
                    default: b.tp = b.ti;
                endcase
            end
            if (b.kind == K_LATE) b.s = b.c - longint'($urandom_range(0, 5));
            else                  b.s = b.c + longint'($urandom_range(1, 15));
            if (b.kind == K_OK && $urandom_range(0, 3) == 0)
                b.stop_at = b.c + longint'($urandom_range(1, 32'(end_time(b) - b.c)));
            run_burst(b, $sformatf("rand%0d", i));
            last_cnt = longint'(model_at(b, end_time(b)).cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
